// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, timing defaults, NOP bus values
// and the read-controller state encoding.
package sdram_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_READ = 4'b0101;
    localparam logic [3:0] CMD_BST  = 4'b0110;
    localparam logic [3:0] CMD_PREC = 4'b0010;

    localparam int CL_DEF   = 3;
    localparam int TRCD_DEF = 2;
    localparam int TRP_DEF  = 2;

    // Bank and address lines are driven all-ones whenever the command is NOP
    localparam logic NOP_FILL = 1'b1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ACT,
        S_TRCD,
        S_READ,
        S_CL,
        S_DATA,
        S_PREC,
        S_TRP,
        S_END
    } rd_state_e;

endpackage

// File: rtl/sdram_seg_calc.sv
// Per-row segment length (bounded by the words left and the end of the page)
// and the next {bank,row} with row overflow carrying into the bank.
module sdram_seg_calc #(
    parameter int BANK_W = 2,
    parameter int ROW_W  = 13,
    parameter int COL_W  = 9,
    parameter int LEN_W  = 10
) (
    input  logic [LEN_W-1:0]  rem,
    input  logic [COL_W-1:0]  col,
    input  logic [BANK_W-1:0] bank,
    input  logic [ROW_W-1:0]  row,
    output logic [LEN_W-1:0]  seg_len,
    output logic [BANK_W-1:0] nxt_bank,
    output logic [ROW_W-1:0]  nxt_row
);

    // One extra bit so a full page (2^COL_W) is representable
    localparam int SW = ((LEN_W > COL_W) ? LEN_W : COL_W) + 1;
    localparam int BRW = BANK_W + ROW_W;

    logic [SW-1:0]  page_left;
    logic [SW-1:0]  rem_w;
    logic [BRW-1:0] br_inc;

    always_comb begin
        page_left = (SW'(1) << COL_W) - SW'(col);
        rem_w     = SW'(rem);
        // page_left is only chosen when it does not exceed rem, so it fits LEN_W
        seg_len   = (rem_w < page_left) ? rem : LEN_W'(page_left);
        br_inc    = {bank, row} + BRW'(1);
        nxt_bank  = br_inc[BRW-1:ROW_W];
        nxt_row   = br_inc[ROW_W-1:0];
    end

endmodule

// File: rtl/sdram_read_paged.sv
// Full-page SDRAM burst reader: splits a request into per-row segments, each
// ACT / READ / BST / PREC, and streams the returned words out with rd_ack.
//
// state  | meaning
// IDLE   | waiting for rd_en with init_end
// ACT    | row activate on the bus
// TRCD   | NOPs for tRCD
// READ   | READ command on the bus (cycle N of the segment)
// CL     | CAS latency wait before the first word
// DATA   | capturing one word per cycle from DQ
// PREC   | precharge on the bus
// TRP    | NOPs for tRP, then next row or finish
// END    | finished; rd_end pulses on the following cycle
module sdram_read_paged
    import sdram_pkg::*;
#(
    parameter int DW     = 16,
    parameter int BANK_W = 2,
    parameter int ROW_W  = 13,
    parameter int COL_W  = 9,
    parameter int LEN_W  = 10,
    parameter int CL     = CL_DEF,
    parameter int TRCD   = TRCD_DEF,
    parameter int TRP    = TRP_DEF
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          init_end,
    input  logic                          rd_en,
    input  logic [BANK_W+ROW_W+COL_W-1:0] rd_addr,
    input  logic [LEN_W-1:0]              rd_burst_len,
    input  logic [DW-1:0]                 rd_sdram_data,
    output logic                          rd_ack,
    output logic [DW-1:0]                 rd_data,
    output logic                          rd_end,
    output logic                          rd_busy,
    output logic [3:0]                    rd_sdram_cmd,
    output logic [BANK_W-1:0]             rd_sdram_bank,
    output logic [ROW_W-1:0]              rd_sdram_addr
);

    localparam int AW = BANK_W + ROW_W + COL_W;
    localparam logic [BANK_W-1:0] NOP_BANK = {BANK_W{NOP_FILL}};
    localparam logic [ROW_W-1:0]  NOP_ADDR = {ROW_W{NOP_FILL}};
    localparam logic [LEN_W-1:0]  ONE      = LEN_W'(1);

    rd_state_e         state_q, state_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [LEN_W-1:0]  tmr_q, tmr_d;
    logic [LEN_W-1:0]  bst_q, bst_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [BANK_W-1:0] ba_q, ba_d;
    logic [ROW_W-1:0]  addr_q, addr_d;
    logic              ack_q, ack_d;
    logic [DW-1:0]     data_q, data_d;
    logic              end_q, end_d;
    logic              busy_q, busy_d;

    logic [LEN_W-1:0]  seg_len;
    logic [BANK_W-1:0] nxt_bank;
    logic [ROW_W-1:0]  nxt_row;

    sdram_seg_calc #(
        .BANK_W (BANK_W),
        .ROW_W  (ROW_W),
        .COL_W  (COL_W),
        .LEN_W  (LEN_W)
    ) u_seg_calc (
        .rem      (rem_q),
        .col      (col_q),
        .bank     (bank_q),
        .row      (row_q),
        .seg_len  (seg_len),
        .nxt_bank (nxt_bank),
        .nxt_row  (nxt_row)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        tmr_d   = tmr_q;
        bst_d   = bst_q;
        bank_d  = bank_q;
        row_d   = row_q;
        col_d   = col_q;
        cmd_d   = CMD_NOP;
        ba_d    = NOP_BANK;
        addr_d  = NOP_ADDR;
        ack_d   = 1'b0;
        data_d  = '0;
        end_d   = (state_q == S_END);

        // BST countdown runs from the READ cycle, independent of the CL/DATA timer
        if (bst_q != '0) begin
            bst_d = bst_q - ONE;
        end
        if (bst_q == ONE) begin
            cmd_d = CMD_BST;
        end

        case (state_q)
            S_IDLE: begin
                if (init_end && rd_en) begin
                    bank_d = rd_addr[AW-1 -: BANK_W];
                    row_d  = rd_addr[COL_W +: ROW_W];
                    col_d  = rd_addr[COL_W-1:0];
                    rem_d  = rd_burst_len;
                    if (rd_burst_len == '0) begin
                        state_d = S_END;
                    end else begin
                        state_d = S_ACT;
                        cmd_d   = CMD_ACT;
                        ba_d    = rd_addr[AW-1 -: BANK_W];
                        addr_d  = rd_addr[COL_W +: ROW_W];
                    end
                end
            end
            S_ACT: begin
                state_d = S_TRCD;
                tmr_d   = LEN_W'(TRCD);
            end
            S_TRCD: begin
                if (tmr_q == ONE) begin
                    state_d = S_READ;
                    cmd_d   = CMD_READ;
                    ba_d    = bank_q;
                    addr_d  = ROW_W'(col_q);
                    bst_d   = seg_len;
                end else begin
                    tmr_d = tmr_q - ONE;
                end
            end
            S_READ: begin
                state_d = S_CL;
                tmr_d   = LEN_W'(CL - 1);
            end
            S_CL: begin
                if (tmr_q == ONE) begin
                    state_d = S_DATA;
                    tmr_d   = seg_len;
                end else begin
                    tmr_d = tmr_q - ONE;
                end
            end
            S_DATA: begin
                ack_d  = 1'b1;
                data_d = rd_sdram_data;
                if (tmr_q == ONE) begin
                    state_d = S_PREC;
                    cmd_d   = CMD_PREC;
                    ba_d    = bank_q;
                    addr_d  = '0;
                    rem_d   = rem_q - seg_len;
                    bank_d  = nxt_bank;
                    row_d   = nxt_row;
                    col_d   = '0;
                end else begin
                    tmr_d = tmr_q - ONE;
                end
            end
            S_PREC: begin
                state_d = S_TRP;
                tmr_d   = LEN_W'(TRP);
            end
            S_TRP: begin
                if (tmr_q == ONE) begin
                    if (rem_q != '0) begin
                        state_d = S_ACT;
                        cmd_d   = CMD_ACT;
                        ba_d    = bank_q;
                        addr_d  = row_q;
                    end else begin
                        state_d = S_END;
                    end
                end else begin
                    tmr_d = tmr_q - ONE;
                end
            end
            S_END: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE) || (state_q == S_END);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            tmr_q   <= '0;
            bst_q   <= '0;
            bank_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            cmd_q   <= CMD_NOP;
            ba_q    <= NOP_BANK;
            addr_q  <= NOP_ADDR;
            ack_q   <= 1'b0;
            data_q  <= '0;
            end_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            tmr_q   <= tmr_d;
            bst_q   <= bst_d;
            bank_q  <= bank_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cmd_q   <= cmd_d;
            ba_q    <= ba_d;
            addr_q  <= addr_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            end_q   <= end_d;
            busy_q  <= busy_d;
        end
    end

    assign rd_ack        = ack_q;
    assign rd_data       = data_q;
    assign rd_end        = end_q;
    assign rd_busy       = busy_q;
    assign rd_sdram_cmd  = cmd_q;
    assign rd_sdram_bank = ba_q;
    assign rd_sdram_addr = addr_q;

endmodule
